// File: rtl/inst_enc_if.sv
// Instruction-encoder handshake bundle: decoded fields in, encoded word out.
// master drives the request side and out_ready; slave is the encoder.
interface inst_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [31:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_pc;
  logic        out_err;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_word, out_pc, out_err
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_word, out_pc, out_err
  );
endinterface

// File: rtl/inst_enc.sv
// MIPS-style instruction encoder with one output register and a running pc.
// Define INST_ENC_RANGE_CHECK_EN to flag out-of-range branch/jump targets in out_err.
module inst_enc (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pc_load,
  input  logic [31:0] pc_load_val,
  inst_enc_if.slave   bus,
  output logic [15:0] count
);

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_SLL   = 5'd1;
  localparam logic [4:0] OP_SRL   = 5'd2;
  localparam logic [4:0] OP_SRA   = 5'd3;
  localparam logic [4:0] OP_JR    = 5'd4;
  localparam logic [4:0] OP_ADDU  = 5'd5;
  localparam logic [4:0] OP_SUBU  = 5'd6;
  localparam logic [4:0] OP_AND   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_BEQ   = 5'd10;
  localparam logic [4:0] OP_BNE   = 5'd11;
  localparam logic [4:0] OP_J     = 5'd12;
  localparam logic [4:0] OP_JAL   = 5'd13;
  localparam logic [4:0] OP_ADDIU = 5'd14;
  localparam logic [4:0] OP_ORI   = 5'd15;
  localparam logic [4:0] OP_LUI   = 5'd16;
  localparam logic [4:0] OP_LW    = 5'd17;
  localparam logic [4:0] OP_SW    = 5'd18;
  localparam logic [4:0] OP_MUL   = 5'd19;

  logic        out_valid_reg;
  logic [31:0] out_word_reg;
  logic [31:0] out_pc_reg;
  logic        out_err_reg;
  logic [15:0] count_reg;
  logic [31:0] pc_reg;

  logic        accept;
  logic        deliver;
  logic [31:0] pc_plus4;
  logic [31:0] diff;
  logic [15:0] branch_imm;
  logic [20:0] r_base;
  logic [25:0] i_base;
  logic        branch_bad;
  logic        jump_bad;
  logic        range_unused;
  logic [31:0] word_next;
  logic        err_next;

  assign bus.in_ready = !pc_load && (!out_valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign deliver      = out_valid_reg && bus.out_ready;

  // Low 16 bits of (diff >>> 2) are simply diff[17:2]; no shifter needed.
  assign pc_plus4   = pc_reg + 32'd4;
  assign diff       = bus.in_target - pc_plus4;
  assign branch_imm = diff[17:2];
  assign r_base     = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd};
  assign i_base     = {bus.in_rs, bus.in_rt, bus.in_imm};

`ifdef INST_ENC_RANGE_CHECK_EN
  // Offset fits in 16 signed bits only if diff[31:17] is a pure sign extension.
  assign branch_bad   = (diff[31:17] != {15{diff[31]}}) || (bus.in_target[1:0] != 2'b00);
  assign jump_bad     = (bus.in_target[1:0] != 2'b00) ||
                        (bus.in_target[31:28] != pc_plus4[31:28]);
  assign range_unused = ^diff[1:0];
`else
  assign branch_bad   = 1'b0;
  assign jump_bad     = 1'b0;
  assign range_unused = ^{diff[31:18], diff[1:0]};
`endif

  always_comb begin
    word_next = 32'h0;
    err_next  = 1'b0;
    case (bus.in_op)
      OP_NOP:   word_next = 32'h0;
      OP_SLL:   word_next = {r_base, bus.in_shamt, 6'h00};
      OP_SRL:   word_next = {r_base, bus.in_shamt, 6'h02};
      OP_SRA:   word_next = {r_base, bus.in_shamt, 6'h03};
      OP_JR:    word_next = {6'h00, bus.in_rs, 15'h0, 6'h08};
      OP_ADDU:  word_next = {r_base, 5'h0, 6'h21};
      OP_SUBU:  word_next = {r_base, 5'h0, 6'h23};
      OP_AND:   word_next = {r_base, 5'h0, 6'h24};
      OP_OR:    word_next = {r_base, 5'h0, 6'h25};
      OP_SLT:   word_next = {r_base, 5'h0, 6'h2a};
      OP_BEQ: begin
        word_next = {6'h04, bus.in_rs, bus.in_rt, branch_imm};
        err_next  = branch_bad;
      end
      OP_BNE: begin
        word_next = {6'h05, bus.in_rs, bus.in_rt, branch_imm};
        err_next  = branch_bad;
      end
      OP_J: begin
        word_next = {6'h02, bus.in_target[27:2]};
        err_next  = jump_bad;
      end
      OP_JAL: begin
        word_next = {6'h03, bus.in_target[27:2]};
        err_next  = jump_bad;
      end
      OP_ADDIU: word_next = {6'h09, i_base};
      OP_ORI:   word_next = {6'h0d, i_base};
      OP_LUI:   word_next = {6'h0f, 5'h0, bus.in_rt, bus.in_imm};
      OP_LW:    word_next = {6'h23, i_base};
      OP_SW:    word_next = {6'h2b, i_base};
      OP_MUL:   word_next = {6'h1c, bus.in_rs, bus.in_rt, bus.in_rd, 5'h0, 6'h02};
      default: begin
        word_next = 32'h0;
        err_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      out_word_reg  <= 32'h0;
      out_pc_reg    <= 32'h0;
      out_err_reg   <= 1'b0;
      count_reg     <= 16'h0;
      pc_reg        <= 32'h0;
    end else begin
      if (pc_load) begin
        pc_reg <= pc_load_val;
      end else if (accept) begin
        pc_reg <= pc_plus4;
      end
      // Accept wins over deliver so a simultaneous hand-off reloads with no bubble.
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_word_reg  <= word_next;
        out_pc_reg    <= pc_reg;
        out_err_reg   <= err_next;
      end else if (deliver) begin
        out_valid_reg <= 1'b0;
      end
      if (deliver) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_word  = out_word_reg;
  assign bus.out_pc    = out_pc_reg;
  assign bus.out_err   = out_err_reg;
  assign count         = count_reg;

endmodule

// File: tb/tb_inst_enc.sv
// Self-checking bench for inst_enc: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literals.
module tb_inst_enc;

`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic [15:0] count;

  inst_enc_if bus ();

  inst_enc dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .bus         (bus),
    .count       (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  exp_t        q[$];
  logic [31:0] m_pc;
  logic [15:0] m_count;
  bit          last_accept;
  bit          m_rdy;
  bit          m_dlv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic longint r_word(int fn, int rs, int rt, int rd, int sh);
    return longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 +
           longint'(sh) * 64 + longint'(fn);
  endfunction

  function automatic longint i_word(int opc, int rs, int rt, int imm);
    return longint'(opc) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 +
           longint'(imm);
  endfunction

  // Reference encoding straight from the instruction-set rules.
  function automatic exp_t encode(int op, int rs, int rt, int rd, int sh, int imm,
                                  logic [31:0] tgt, logic [31:0] pc);
    exp_t        e;
    longint      w;
    logic [31:0] pc4;
    int          d, off;
    bit          berr, jerr;
    pc4  = pc + 32'd4;
    d    = int'(tgt - pc4);
    off  = d >>> 2;
    berr = RC && ((off < -32768) || (off > 32767) || (tgt % 4 != 0));
    jerr = RC && ((tgt % 4 != 0) || (tgt / 32'h10000000 != pc4 / 32'h10000000));
    e.pc  = pc;
    e.err = 1'b0;
    w     = 0;
    case (op)
      0:  w = 0;
      1:  w = r_word(8'h00, rs, rt, rd, sh);
      2:  w = r_word(8'h02, rs, rt, rd, sh);
      3:  w = r_word(8'h03, rs, rt, rd, sh);
      4:  w = r_word(8'h08, rs, 0, 0, 0);
      5:  w = r_word(8'h21, rs, rt, rd, 0);
      6:  w = r_word(8'h23, rs, rt, rd, 0);
      7:  w = r_word(8'h24, rs, rt, rd, 0);
      8:  w = r_word(8'h25, rs, rt, rd, 0);
      9:  w = r_word(8'h2a, rs, rt, rd, 0);
      10: begin w = i_word(8'h04, rs, rt, off & 'hFFFF); e.err = berr; end
      11: begin w = i_word(8'h05, rs, rt, off & 'hFFFF); e.err = berr; end
      12: begin w = longint'(2) * 67108864 + longint'(tgt % 32'h10000000) / 4; e.err = jerr; end
      13: begin w = longint'(3) * 67108864 + longint'(tgt % 32'h10000000) / 4; e.err = jerr; end
      14: w = i_word(8'h09, rs, rt, imm);
      15: w = i_word(8'h0d, rs, rt, imm);
      16: w = i_word(8'h0f, 0, rt, imm);
      17: w = i_word(8'h23, rs, rt, imm);
      18: w = i_word(8'h2b, rs, rt, imm);
      19: w = longint'(8'h1c) * 67108864 + r_word(8'h02, rs, rt, rd, 0);
      default: begin w = 0; e.err = 1'b1; end
    endcase
    e.word = w[31:0];
    return e;
  endfunction

  // Model: one-deep output slot as a queue, pc and delivered count.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_pc        = 32'h0;
      m_count     = 16'h0;
      last_accept = 1'b0;
    end else begin
      m_rdy       = !pc_load && (q.size() == 0 || bus.out_ready);
      m_dlv       = (q.size() != 0) && bus.out_ready;
      last_accept = bus.in_valid && m_rdy;
      if (m_dlv) begin
        void'(q.pop_front());
        m_count = m_count + 16'd1;
      end
      if (last_accept)
        q.push_back(encode(int'(bus.in_op), int'(bus.in_rs), int'(bus.in_rt), int'(bus.in_rd),
                           int'(bus.in_shamt), int'(bus.in_imm), bus.in_target, m_pc));
      if (pc_load) m_pc = pc_load_val;
      else if (last_accept) m_pc = m_pc + 32'd4;
    end
  end

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("out_word", bus.out_word, q[0].word);
        chk("out_pc", bus.out_pc, q[0].pc);
        chk("out_err", {31'b0, bus.out_err}, {31'b0, q[0].err});
      end
      chk("in_ready", {31'b0, bus.in_ready},
          {31'b0, !pc_load && (q.size() == 0 || bus.out_ready)});
      chk("count", {16'b0, count}, {16'b0, m_count});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [31:0] tgt);
    int n;
    bus.in_op     = op;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_shamt  = sh;
    bus.in_imm    = imm;
    bus.in_target = tgt;
    bus.in_valid  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_accept && n < 40);
    if (!last_accept) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d not accepted within %0d cycles", op, n);
    end
    $display("txn op=%0d pc=%h word=%h err=%0b count=%0d", op, bus.out_pc, bus.out_word,
             bus.out_err, count);
    bus.in_valid = 1'b0;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load     = 1'b1;
    pc_load_val = v;
    tick();
    pc_load     = 1'b0;
  endtask

  exp_t e;

  initial begin
    reset_n       = 1'b1;
    pc_load       = 1'b0;
    pc_load_val   = 32'h0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 5'd0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_shamt  = 5'd0;
    bus.in_imm    = 16'h0;
    bus.in_target = 32'h0;
    bus.out_ready = 1'b1;

    // Pin the model against hand-computed words.
    e = encode(5, 1, 2, 3, 0, 0, 32'h0, 32'h00400000);
    chk("pin_addu", e.word, 32'h00221821);
    e = encode(10, 1, 2, 0, 0, 0, 32'h00400000, 32'h00400004);
    chk("pin_beq", e.word, 32'h1022FFFE);
    e = encode(12, 0, 0, 0, 0, 0, 32'h00400100, 32'h00400008);
    chk("pin_j", e.word, 32'h08100040);
    e = encode(17, 29, 8, 0, 0, 16'hFFFC, 32'h0, 32'h0);
    chk("pin_lw", e.word, 32'h8FA8FFFC);
    e = encode(25, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("pin_undef", {e.err, e.word[30:0]}, 32'h80000000);
    e = encode(11, 1, 2, 0, 0, 0, 32'h00420004, 32'h00400000);
    chk("pin_bne_range", {31'b0, e.err}, {31'b0, RC});

    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_out_word", bus.out_word, 32'h0);
    chk("rst_count", {16'b0, count}, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    load_pc(32'h00400000);
    send(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0);
    chk("lit_addu_word", bus.out_word, 32'h00221821);
    chk("lit_addu_pc", bus.out_pc, 32'h00400000);
    send(5'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'h00400000);
    chk("lit_beq_word", bus.out_word, 32'h1022FFFE);
    send(5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h00400100);
    chk("lit_j_word", bus.out_word, 32'h08100040);
    send(5'd17, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 32'h0);
    chk("lit_lw_word", bus.out_word, 32'h8FA8FFFC);
    send(5'd25, 5'd3, 5'd4, 5'd5, 5'd6, 16'h1111, 32'h0);
    chk("lit_undef_err", {31'b0, bus.out_err}, 32'h1);

    // Every op with stray shamt/rs values that must be masked where unused.
    for (int op = 0; op < 22; op++)
      send(5'(op), 5'(op + 1), 5'(30 - op), 5'(op * 3), 5'(op + 7), 16'(16'h1234 + op),
           32'h00400040);

    // Back-pressure: second word waits, first stays stable, both drain in order.
    tick();
    bus.out_ready = 1'b0;
    send(5'd7, 5'd9, 5'd10, 5'd11, 5'd0, 16'h0, 32'h0);
    fork
      send(5'd8, 5'd12, 5'd13, 5'd14, 5'd0, 16'h0, 32'h0);
      begin
        repeat (3) tick();
        chk("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
        bus.out_ready = 1'b1;
      end
    join
    tick();

    send(5'd11, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, m_pc + 32'd4 + 32'h20000);
    chk("bne_range_err", {31'b0, bus.out_err}, {31'b0, RC});
    send(5'd13, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h10000002);

    // pc_load with a word in flight leaves the word alone.
    tick();
    bus.out_ready = 1'b0;
    send(5'd15, 5'd2, 5'd3, 5'd0, 5'd0, 16'hBEEF, 32'h0);
    load_pc(32'h00001000);
    bus.out_ready = 1'b1;
    send(5'd16, 5'd7, 5'd4, 5'd0, 5'd0, 16'hCAFE, 32'h0);
    chk("lit_pcload_pc", bus.out_pc, 32'h00001000);

    load_pc(32'hFFFFFFFC);
    send(5'd14, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0001, 32'h0);
    send(5'd18, 5'd2, 5'd2, 5'd0, 5'd0, 16'h0002, 32'h0);
    chk("lit_wrap_pc", bus.out_pc, 32'h0);

    // Reset while a word is held.
    tick();
    bus.out_ready = 1'b0;
    load_pc(32'h00400000);
    send(5'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("midrst_count", {16'b0, count}, 32'h0);
    chk("midrst_out_pc", bus.out_pc, 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    send(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0);
    chk("lit_after_rst_pc", bus.out_pc, 32'h0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_enc.md
INST_ENC -- requirements
Module: inst_enc

Interface
REQ-001 SHALL have port clock, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port pc_load, input, 1: load program counter from pc_load_val.
REQ-004 SHALL have port pc_load_val, input, 32: new program counter value.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-006 SHALL have port in_op, input, 5: operation select, encoded per REQ-016.
REQ-007 SHALL have ports in_rs, in_rt, in_rd, in_shamt, all input, 5 each: register and shift fields.
REQ-008 SHALL have ports in_imm (input, 16) and in_target (input, 32): immediate, and branch/jump target byte address.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-010 SHALL have ports out_word (output, 32) and out_pc (output, 32): encoded instruction word and its address.
REQ-011 SHALL have port out_err (output, 1): illegal op or out-of-range field for this word.
REQ-012 SHALL have port count, output, 16: number of words delivered; wraps 0xFFFF->0.

Function
REQ-013 SHALL hold one output register: in_ready = !pc_load && (!out_valid || out_ready).
REQ-014 SHALL accept on in_valid&&in_ready; out_word/out_pc/out_err valid the next cycle (latency 1).
REQ-015 SHALL keep out_word, out_pc, out_err stable while out_valid && !out_ready.
REQ-016 in_op SHALL map to: 0 NOP, 1 SLL, 2 SRL, 3 SRA, 4 JR, 5 ADDU, 6 SUBU, 7 AND, 8 OR, 9 SLT, 10 BEQ, 11 BNE, 12 J, 13 JAL, 14 ADDIU, 15 ORI, 16 LUI, 17 LW, 18 SW, 19 MUL.
REQ-017 R-type SHALL encode {6'h00, rs, rt, rd, shamt, funct}; shamt is forced to 0 except for SLL/SRL/SRA; JR uses rs only; NOP encodes 32'h0.
REQ-018 MUL SHALL encode {6'h1c, rs, rt, rd, 5'h0, 6'h02}; I-type ops SHALL encode {opc, rs, rt, imm}; LUI forces rs=0.
REQ-019 BEQ/BNE SHALL compute offset = (in_target - (pc+4)) >>> 2, 32-bit two's complement, and place the low 16 bits in imm.
REQ-020 J/JAL SHALL encode {opc, in_target[27:2]}.
REQ-021 Undefined in_op (20-31) SHALL emit out_word = 0 with out_err = 1.
REQ-022 Internal pc SHALL be stamped into out_pc at accept; pc += 4 per accept; 0xFFFFFFFC wraps to 0.
REQ-023 pc_load SHALL set pc = pc_load_val; no accept occurs that cycle; an in-flight output is unaffected.
REQ-024 count SHALL increment on each out_valid&&out_ready cycle.
REQ-025 With out_valid&&out_ready&&in_valid in the same cycle, SHALL deliver and accept simultaneously; the register reloads with no bubble.

Reset
REQ-026 reset_n low SHALL immediately clear out_valid, out_err, out_word, out_pc, count and pc to 0.
REQ-027 Reset mid-transfer SHALL drop the held word; the first accept after release uses pc=0 unless pc_load is asserted first.

Configuration
REQ-028 Macro INST_ENC_RANGE_CHECK_EN defined: out_err SHALL also assert when the branch offset lies outside [-32768, 32767], the branch/jump target[1:0] != 0, or the J/JAL target[31:28] != (pc+4)[31:28]; the word is still emitted with truncated fields.
REQ-029 Macro not defined: out_err SHALL flag only undefined in_op; no range logic SHALL be present.

Verification
REQ-030 pc_load 0x00400000; ADDU rd=3 rs=1 rt=2 -> out_word 0x00221821, out_pc 0x00400000, out_err 0, one cycle later.
REQ-031 At pc 0x00400004, BEQ rs=1 rt=2 target 0x00400000 -> out_word 0x1022FFFE; then J target 0x00400100 -> out_word 0x08100040.
REQ-032 LW rt=8 rs=29 imm 0xFFFC -> out_word 0x8FA8FFFC; in_op 25 -> out_word 0, out_err 1.
REQ-033 Hold out_ready=0 while offering 2 instructions -> first word held stable, in_ready 0; release -> both delivered in order, pcs +4 apart, count +2.
REQ-034 BNE target = pc+4+0x20000 -> out_err 1 with INST_ENC_RANGE_CHECK_EN, 0 without.
REQ-035 Assert reset_n low while out_valid=1 -> out_valid, count and pc read 0 before the next clock edge.
